// File: rtl/adder_avmm_slave_if.sv
// Avalon-MM slave bus bundle for the HPS adder responder.
// Read data has a fixed latency of one cycle.
interface adder_avmm_slave_if;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/adder_avmm_slave.sv
// 64-bit chunked ripple adder behind an Avalon-MM slave with start/done handshake.
// Optional subtract mode: define ADDER_AVMM_SUB_EN.
module adder_avmm_slave #(
    parameter int          CHUNK_W  = 16,
    parameter logic [31:0] ID_VALUE = 32'hADD0_0001
) (
    input  logic                clk,
    input  logic                reset_n,
    adder_avmm_slave_if.slave   avs,
    output logic                irq
);
    localparam int N  = 64 / CHUNK_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int CX = CHUNK_W + 1;

    typedef enum logic {IDLE, ADD} state_t;

    state_t state_q, state_d;

    logic [63:0]   a_q, b_q, sum_q, work_q, work_d;
    logic [CW-1:0] cnt_q;
    logic          carry_run_q, carry_q;
    logic          done_q, err_q, irq_en_q, sub_q;
    logic [31:0]   rdata_q, rd_mux, status;

    logic          busy, last;
    logic          op_wr, ctrl_wr, start;
    logic [5:0]    off;
    logic [CHUNK_W-1:0] a_ch, b_ch, b_eff, s_ch;
    logic          c_out;

    logic [31:0] wd;
    assign wd = avs.avs_writedata;

    assign op_wr   = avs.avs_write && !avs.avs_address[2];
    assign ctrl_wr = avs.avs_write && (avs.avs_address == 3'd6);
    assign start   = ctrl_wr && wd[0] && !busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ADD;
            ADD:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ADD);
        last = busy && (cnt_q == CW'(N - 1));
    end

    always_comb begin
        off  = 6'(int'(cnt_q) * CHUNK_W);
        a_ch = a_q[off +: CHUNK_W];
        b_ch = b_q[off +: CHUNK_W];
`ifdef ADDER_AVMM_SUB_EN
        b_eff = sub_q ? ~b_ch : b_ch;
`else
        b_eff = b_ch;
`endif
        {c_out, s_ch} = {1'b0, a_ch} + {1'b0, b_eff} + CX'(carry_run_q);
        work_d = work_q;
        work_d[off +: CHUNK_W] = s_ch;
    end

    assign status = {26'd0, sub_q, irq_en_q, err_q, carry_q, done_q, busy};

    always_comb begin
        rd_mux = '0;
        unique case (avs.avs_address)
            3'd0:    rd_mux = a_q[31:0];
            3'd1:    rd_mux = a_q[63:32];
            3'd2:    rd_mux = b_q[31:0];
            3'd3:    rd_mux = b_q[63:32];
            3'd4:    rd_mux = sum_q[31:0];
            3'd5:    rd_mux = sum_q[63:32];
            3'd6:    rd_mux = status;
            default: rd_mux = ID_VALUE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            carry_run_q <= 1'b0;
            carry_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            // Read mux sees pre-write state, so same-address R/W returns old data.
            rdata_q <= avs.avs_read ? rd_mux : 32'd0;

            if (op_wr) begin
                if (busy) begin
                    err_q <= 1'b1;
                end else begin
                    done_q <= 1'b0;
                    unique case (avs.avs_address[1:0])
                        2'd0:    a_q[31:0]  <= wd;
                        2'd1:    a_q[63:32] <= wd;
                        2'd2:    b_q[31:0]  <= wd;
                        default: b_q[63:32] <= wd;
                    endcase
                end
            end

            if (ctrl_wr) begin
                irq_en_q <= wd[4];
                if (wd[3]) err_q <= 1'b0;
            end

            if (start) begin
                done_q <= 1'b0;
                cnt_q  <= '0;
`ifdef ADDER_AVMM_SUB_EN
                carry_run_q <= wd[1];
`else
                carry_run_q <= 1'b0;
`endif
            end

            if (busy) begin
                work_q      <= work_d;
                carry_run_q <= c_out;
                cnt_q       <= cnt_q + CW'(1);
                if (last) begin
                    sum_q   <= work_d;
                    carry_q <= c_out;
                    done_q  <= 1'b1;
                end
            end
        end
    end

`ifdef ADDER_AVMM_SUB_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   sub_q <= 1'b0;
        else if (start) sub_q <= wd[1];
    end
    logic unused_wd;
    assign unused_wd = ^{wd[31:5], wd[2]};
`else
    assign sub_q = 1'b0;
    logic unused_wd;
    assign unused_wd = ^{wd[31:5], wd[2:1]};
`endif

    assign avs.avs_readdata = rdata_q;
    assign irq = done_q & irq_en_q;
endmodule

// File: tb/tb_adder_avmm_slave.sv
// Scoreboard bench for adder_avmm_slave: directed register traffic,
// expected read data queued at issue and checked by a monitor.
module tb_adder_avmm_slave;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic irq;
    int   tests = 0;
    int   fails = 0;

    adder_avmm_slave_if bus();

    adder_avmm_slave dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (bus),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_seen = 1'b0;

    always @(posedge clk) rd_seen <= bus.avs_read;

    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_seen) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_read got=%h", bus.avs_readdata);
                end else begin
                    automatic logic [31:0] e = exp_q.pop_front();
                    automatic string n = name_q.pop_front();
                    if (bus.avs_readdata !== e) begin
                        fails++;
                        $display("FAIL %s got=%h exp=%h", n, bus.avs_readdata, e);
                    end
                end
            end else if (bus.avs_readdata !== 32'd0) begin
                tests++;
                fails++;
                $display("FAIL idle_readdata got=%h exp=0", bus.avs_readdata);
            end
        end
    end

    task automatic drive_clear();
        bus.avs_write     = 1'b0;
        bus.avs_read      = 1'b0;
        bus.avs_address   = 3'd0;
        bus.avs_writedata = 32'd0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_address = a;
        bus.avs_writedata = d;
        bus.avs_write = 1'b1;
        @(posedge clk);
        #1 drive_clear();
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        @(negedge clk);
        exp_q.push_back(e);
        name_q.push_back(n);
        bus.avs_address = a;
        bus.avs_read = 1'b1;
        @(posedge clk);
        #1 drive_clear();
    endtask

    task automatic rw(input logic [2:0] a, input logic [31:0] d,
                      input logic [31:0] e, input string n);
        @(negedge clk);
        exp_q.push_back(e);
        name_q.push_back(n);
        bus.avs_address = a;
        bus.avs_writedata = d;
        bus.avs_write = 1'b1;
        bus.avs_read = 1'b1;
        @(posedge clk);
        #1 drive_clear();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_irq(input logic e, input string n);
        tests++;
        if (irq !== e) begin
            fails++;
            $display("FAIL %s irq=%b exp=%b", n, irq, e);
        end
    endtask

    task automatic load(input logic [63:0] a, input logic [63:0] b);
        wr(3'd0, a[31:0]);
        wr(3'd1, a[63:32]);
        wr(3'd2, b[31:0]);
        wr(3'd3, b[63:32]);
    endtask

    logic [31:0] rst_exp [8];

    initial begin
        drive_clear();
        rst_exp = '{0, 0, 0, 0, 0, 0, 0, 32'hADD0_0001};
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        chk_irq(1'b0, "reset_irq");
        for (int i = 0; i < 8; i++)
            rd(3'(i), rst_exp[i], $sformatf("reset_addr%0d", i));

        // all-ones + 1: carry ripples through every chunk
        load(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wr(3'd6, 32'h1);
        for (int i = 0; i < 4; i++)
            rd(3'd6, 32'h01, $sformatf("carry_busy%0d", i));
        rd(3'd6, 32'h06, "carry_status");
        rd(3'd4, 32'h0, "carry_sum_lo");
        rd(3'd5, 32'h0, "carry_sum_hi");
        rd(3'd0, 32'hFFFF_FFFF, "carry_a_lo");

        load(64'h0000_0001_8000_0000, 64'h0000_0002_8000_0000);
        rd(3'd6, 32'h04, "opwr_clears_done");
        wr(3'd6, 32'h1);
        idle(4);
        rd(3'd4, 32'h0, "plain_sum_lo");
        rd(3'd5, 32'h4, "plain_sum_hi");
        rd(3'd6, 32'h02, "plain_status");

        // operand write while busy is dropped and flags err
        wr(3'd6, 32'h1);
        wr(3'd0, 32'h1234);
        idle(3);
        rd(3'd6, 32'h0A, "busy_err_status");
        rd(3'd4, 32'h0, "busy_sum_lo");
        rd(3'd5, 32'h4, "busy_sum_hi");
        rd(3'd0, 32'h8000_0000, "busy_a_lo_kept");
        wr(3'd6, 32'h08);
        rd(3'd6, 32'h02, "err_cleared");

        wr(3'd6, 32'h11);
        idle(3);
        chk_irq(1'b0, "irq_before_done");
        idle(1);
        chk_irq(1'b1, "irq_at_done");
        rd(3'd6, 32'h12, "irq_status");
        wr(3'd0, 32'h3);
        chk_irq(1'b0, "irq_dropped");
        rd(3'd6, 32'h10, "irq_done_cleared");

        rw(3'd0, 32'h55, 32'h3, "rw_old_value");
        rd(3'd0, 32'h55, "rw_new_value");
        wr(3'd7, 32'hDEAD_BEEF);
        rd(3'd7, 32'hADD0_0001, "id_ro");
        wr(3'd4, 32'hDEAD_BEEF);
        rd(3'd4, 32'h0, "sum_ro");
        wr(3'd6, 32'h0);
        rd(3'd6, 32'h00, "ctrl_no_start");

`ifdef ADDER_AVMM_SUB_EN
        load(64'd5, 64'd7);
        wr(3'd6, 32'h3);
        idle(4);
        rd(3'd4, 32'hFFFF_FFFE, "sub_neg_lo");
        rd(3'd5, 32'hFFFF_FFFF, "sub_neg_hi");
        rd(3'd6, 32'h22, "sub_neg_status");
        load(64'd7, 64'd5);
        wr(3'd6, 32'h3);
        idle(4);
        rd(3'd4, 32'h2, "sub_pos_lo");
        rd(3'd5, 32'h0, "sub_pos_hi");
        rd(3'd6, 32'h26, "sub_pos_status");
`endif

        idle(2);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adder_avmm_slave.md
# adder_avmm_slave

FPGA-side responder for the HPS adder path: an Avalon-MM slave on the lightweight HPS-to-FPGA bridge that holds two 64-bit operands written by the HPS, computes their 64-bit sum over several cycles with a chunked ripple adder, and returns the sum and status on read. It replaces the free-running operand/sum PIO pair with a start/done handshake, so the HPS always reads a consistent result. An optional level interrupt signals completion.

## Interface

- CHUNK_W, 16, adder bits processed per cycle; must divide 64 (legal: 8, 16, 32, 64); N = 64/CHUNK_W.
- ID_VALUE, 32'hADD0_0001, constant returned at address 7.

- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  3  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, fixed read latency 1.
- irq  out  1  level interrupt = done & irq_en.

Register map (word addresses):
- 0 A_LO, 1 A_HI, 2 B_LO, 3 B_HI: RW operand halves.
- 4 SUM_LO, 5 SUM_HI: RO committed result.
- 6 CTRL/STATUS. Write: bit0 start, bit1 sub (macro only), bit3 write-1-to-clear err, bit4 irq_en. Read: bit0 busy, bit1 done, bit2 carry, bit3 err, bit4 irq_en, bit5 sub.
- 7 ID: RO ID_VALUE.

## Operation

- FSM states: IDLE, ADD.
- IDLE with write of 1 to CTRL bit0: latch sub, clear done, set carry_in = sub, zero the chunk counter, go to ADD.
- ADD: on each cycle k = 0..N-1, compute chunk k of A + (sub ? ~B : B) + carry. Write the result into the working register. Propagate carry.
- After chunk N-1: copy the working register to SUM, store the final carry (carry-out for add, no-borrow for sub), set done, return to IDLE.
- SUM and carry change only at commit and hold between operations.
- busy = (state == ADD).
- Start while busy: ignored. Does not set err.
- Operand write (address 0-3) while busy: dropped; err set (sticky).
- Operand write while idle: accepted; clears done.
- CTRL write with bit0=0: updates irq_en and err-clear only.
- CTRL write setting err-clear and start in the same write: clear err first, then start.
- Writes to RO addresses 4, 5, 7: ignored.
- Simultaneous read and write, same address: read returns the pre-write value.
- Arithmetic: modulo 2^64. No saturation.

## Timing

- Reset values: avs_readdata 0, irq 0, A/B/SUM/working register 0, done/busy/carry/err/irq_en/sub 0, state IDLE.
- Reset asserted mid-ADD: aborts immediately to reset values. No partial commit.
- Start write sampled at edge T:
  - busy = 1 after edge T.
  - Chunk k is computed on edge T+1+k.
  - Commit on edge T+N: busy = 0, done = 1, SUM valid.
  - irq (if irq_en) rises after edge T+N.
  - With CHUNK_W=16: done visible N = 4 cycles after the start edge.
- Read sampled at edge T: avs_readdata valid after edge T, for one cycle; otherwise 0.
- Back-to-back start accepted on the first edge with busy = 0.

## Configuration

- Macro: ADDER_AVMM_SUB_EN.
- Defined: CTRL bit1 selects subtract (A - B via A + ~B + 1). Status bit5 reflects the latched sub.
- Undefined: bit1 is ignored, the block always adds, status bit5 reads 0, and the ~B logic is not synthesized.

## Test plan

- Reset check: after reset, read all 8 addresses -> 0 everywhere except addr 7 = 0xADD00001. irq = 0.
- Carry across all chunks: A = 0xFFFFFFFF_FFFFFFFF, B = 1, start -> busy for 4 cycles, then SUM_LO = SUM_HI = 0, status = 0x06 (done, carry).
- Plain add: A = 0x00000001_80000000, B = 0x00000002_80000000 -> SUM = 0x00000004_00000000, carry 0.
- Busy protection:
  - Start, then write A_LO = 0x1234 on the next cycle -> write dropped, err = 1, result uses the old A.
  - Write CTRL = 0x08 -> err = 0.
- irq: irq_en = 1, start -> irq rises on the same cycle as done. Writing A_LO afterwards clears done and drops irq.
- With ADDER_AVMM_SUB_EN: A = 5, B = 7, CTRL = 0x3 -> SUM = 0xFFFFFFFF_FFFFFFFE, carry 0. A = 7, B = 5 -> SUM = 2, carry 1.
